sm_serial_subtractor: RTL and testbench
=======================================

Name: sm_serial_subtractor

Overview:
- Bit-serial sign-magnitude subtractor: computes diff = a - b on (N+1)-bit sign-magnitude operands, one magnitude bit per clock, LSB first.
- Complements the sign-magnitude adder path. Subtraction is done by inverting b's sign, then adding or subtracting magnitudes, with a serial re-negation pass if the magnitude subtraction borrows.
- Sits between operand and result registers, with valid/ready handshakes on both sides.

Parameters:
N, 4, magnitude width; operands and result are N+1 bits (bit N = sign, 1 = negative; bits N-1:0 = magnitude)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept operands (high only in IDLE)
a  input  N+1  minuend, sign-magnitude
b  input  N+1  subtrahend, sign-magnitude
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
diff  output  N+1  result a - b, sign-magnitude
overflow  output  1  magnitude overflow (|result| >= 2^N), valid with out_valid

Behaviour:
- Reset (rst_n low, asynchronous) forces:
  - state IDLE, bit counter 0, internal carry/borrow 0.
  - out_valid=0, diff=0, overflow=0.
  - in_ready=1, since in_ready is decoded from IDLE.
  - Any operation in progress is aborted and no result is produced.
- States: IDLE -> CALC -> (FIX) -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: latch a, b; sb = ~b[N]; op = ADD if a[N]==sb, else SUB; clear counter and carry/borrow; go to CALC.
- CALC, N cycles:
  - Each cycle processes magnitude bit i = counter, LSB first.
  - ADD: s = ma[i]^mb[i]^c; c' = majority(ma[i], mb[i], c).
  - SUB: d = ma[i]^mb[i]^br; br' = (~ma[i] & mb[i]) | (~(ma[i]^mb[i]) & br).
  - Result bits shift into a result register; counter increments.
- After bit N-1:
  - ADD: sign = a[N], overflow = final carry, magnitude = sum mod 2^N; go to DONE.
  - SUB with final borrow 0: sign = a[N], overflow = 0; go to DONE.
  - SUB with final borrow 1: go to FIX with counter cleared.
- FIX, N cycles:
  - Serial two's-complement negation of the magnitude register: complement each bit and add an initial carry of 1, LSB first.
  - Then sign = sb, overflow = 0; go to DONE.
- Zero result: if the final magnitude is 0, the sign is forced to 0 (no negative zero emitted, even after overflow wrap). -0 inputs are treated as magnitude 0.
- DONE:
  - out_valid=1; diff and overflow are held stable until out_valid & out_ready, then go to IDLE.
  - in_ready is low in DONE; a new operand cannot be accepted in the same cycle as the result handshake.
- Latency, counted in rising edges from the acceptance edge to the first cycle with out_valid high:
  - N edges for no-FIX paths.
  - 2N edges for the FIX path.
  - Throughput: one operation per latency + 2 cycles minimum, with out_ready held high.
- in_valid, a and b are ignored outside IDLE; a, b need not be held after acceptance.
- diff/overflow outside DONE: keep last value; value not guaranteed and must not be checked.

Test Plan (N=4; values written as sign_magnitude):
- a=0_0101 (+5), b=0_0011 (+3), out_ready=1 -> diff=0_0010, overflow=0, out_valid 4 edges after acceptance.
- a=0_0011 (+3), b=0_0101 (+5) -> FIX path; diff=1_0010 (-2), overflow=0, out_valid 8 edges after acceptance.
- a=0_1001 (+9), b=1_1001 (-9) -> ADD path; diff=0_0010 (18 mod 16), overflow=1. Also a=1_0111, b=1_0111 -> diff=0_0000 (sign forced 0).
- a=1_0000 (-0), b=0_0000 (+0) -> diff=0_0000, overflow=0. Also a=0_0000, b=0_1111 -> diff=1_1111.
- Backpressure: result ready, out_ready low for 5 cycles while in_valid toggles with new operands -> out_valid stays 1, diff stable, in_ready=0, no new operand accepted. Raise out_ready -> IDLE next cycle, in_ready=1.
- Reset mid-operation: assert rst_n=0 at CALC bit 2 (off clock edge) -> immediately out_valid=0, diff=0, in_ready=1. After release, a=0_0111, b=0_0001 -> diff=0_0110 with normal latency.
- Random: 1000 random a/b pairs with random out_ready stalls, checked against a reference sign-magnitude model (including overflow and zero-sign rule).

Source files
------------

// File: rtl/sm_serial_subtractor.sv
// Bit-serial sign-magnitude subtractor (diff = a - b), one magnitude bit per clock, LSB first.
// Magnitude subtraction that borrows is followed by a serial two's-complement fix-up pass.
module sm_serial_subtractor #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N:0]   a,
  input  logic [N:0]   b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N:0]   diff,
  output logic         overflow
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_c;
  logic [N-1:0]    r_ma;
  logic [N-1:0]    r_mb;
  logic [N-1:0]    r_res;
  logic            r_sa;
  logic            r_sb;
  logic            r_sub;
  logic            r_out_valid;
  logic [N:0]      r_diff;
  logic            r_ovf;

  logic            w_abit;
  logic            w_bbit;
  logic            w_bit_calc;
  logic            w_c_calc;
  logic            w_bit_fix;
  logic            w_c_fix;
  logic            w_last;
  logic [N-1:0]    w_mag_calc;
  logic [N-1:0]    w_mag_fix;
  logic [N-1:0]    w_fin_mag;
  logic            w_fin_sign;
  logic            w_fin_ovf;

  // Serial add/subtract cell and serial negation cell
  always_comb begin
    w_abit     = r_ma[0];
    w_bbit     = r_mb[0];
    w_bit_calc = w_abit ^ w_bbit ^ r_c;
    if (r_sub)
      w_c_calc = (~w_abit & w_bbit) | (~(w_abit ^ w_bbit) & r_c);
    else
      w_c_calc = (w_abit & w_bbit) | (w_abit & r_c) | (w_bbit & r_c);
    w_bit_fix  = ~r_res[0] ^ r_c;
    w_c_fix    = ~r_res[0] & r_c;
    w_mag_calc = {w_bit_calc, r_res[N-1:1]};
    w_mag_fix  = {w_bit_fix, r_res[N-1:1]};
    w_last     = (r_cnt == CW'(N - 1));
    w_fin_mag  = (r_state == S_FIX) ? w_mag_fix : w_mag_calc;
    w_fin_sign = ((r_state == S_FIX) ? r_sb : r_sa) & (|w_fin_mag);
    w_fin_ovf  = (r_state == S_CALC) & ~r_sub & w_c_calc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_c         <= 1'b0;
      r_ma        <= '0;
      r_mb        <= '0;
      r_res       <= '0;
      r_sa        <= 1'b0;
      r_sb        <= 1'b0;
      r_sub       <= 1'b0;
      r_out_valid <= 1'b0;
      r_diff      <= '0;
      r_ovf       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_ma    <= a[N-1:0];
            r_mb    <= b[N-1:0];
            r_sa    <= a[N];
            r_sb    <= ~b[N];
            // Equal input signs mean the inverted subtrahend sign differs: magnitude subtract
            r_sub   <= (a[N] == b[N]);
            r_cnt   <= '0;
            r_c     <= 1'b0;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          r_ma  <= r_ma >> 1;
          r_mb  <= r_mb >> 1;
          r_res <= w_mag_calc;
          r_c   <= w_c_calc;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            if (r_sub && w_c_calc) begin
              r_state <= S_FIX;
              r_cnt   <= '0;
              r_c     <= 1'b1;
            end else begin
              r_diff      <= {w_fin_sign, w_fin_mag};
              r_ovf       <= w_fin_ovf;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end
          end
        end
        S_FIX: begin
          r_res <= w_mag_fix;
          r_c   <= w_c_fix;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_diff      <= {w_fin_sign, w_fin_mag};
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_out_valid;
  assign diff      = r_diff;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_sm_serial_subtractor.sv
// Directed-table and random-model bench for sm_serial_subtractor at N=4.
module tb_sm_serial_subtractor;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] a;
  logic [4:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] diff;
  logic       overflow;

  int checks;
  int errors;

  sm_serial_subtractor #(.N(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [4:0] a;
    logic [4:0] b;
    logic [4:0] d;
    logic       ov;
    int         lat;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: plain integer sign-magnitude arithmetic
  task automatic model(input logic [4:0] ta, input logic [4:0] tb,
                       output logic [4:0] ed, output logic eo, output int el);
    logic [4:0] s;
    logic [3:0] mag;
    logic       sg;
    logic       sa, sb;
    sa = ta[4];
    sb = ~tb[4];
    el = 4;
    eo = 1'b0;
    if (sa == sb) begin
      s   = {1'b0, ta[3:0]} + {1'b0, tb[3:0]};
      eo  = s[4];
      mag = s[3:0];
      sg  = sa;
    end else if (ta[3:0] >= tb[3:0]) begin
      mag = ta[3:0] - tb[3:0];
      sg  = sa;
    end else begin
      mag = tb[3:0] - ta[3:0];
      sg  = sb;
      el  = 8;
    end
    if (mag == 4'd0) sg = 1'b0;
    ed = {sg, mag};
  endtask

  task automatic run_op(input logic [4:0] ta, input logic [4:0] tb, input logic [4:0] ed,
                        input logic eo, input int el, input int stall, input string nm);
    int cyc;
    cyc = 0;
    while (!in_ready && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({nm, " in_ready idle"}, int'(in_ready), 1);
    a = ta;
    b = tb;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 5'($urandom);
    b = 5'($urandom);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({nm, " latency"}, cyc, el);
    if (!out_valid) return;
    chk({nm, " diff"}, int'(diff), int'(ed));
    chk({nm, " overflow"}, int'(overflow), int'(eo));
    for (int i = 0; i < stall; i++) begin
      in_valid = (i % 2 == 0);
      a = 5'($urandom);
      b = 5'($urandom);
      @(posedge clk); #1;
      chk({nm, " stall out_valid"}, int'(out_valid), 1);
      chk({nm, " stall diff"}, int'(diff), int'(ed));
      chk({nm, " stall in_ready"}, int'(in_ready), 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({nm, " out_valid after hs"}, int'(out_valid), 0);
    chk({nm, " in_ready after hs"}, int'(in_ready), 1);
  endtask

  initial begin
    logic [4:0] ed;
    logic       eo;
    int         el;
    logic [4:0] ra, rb;

    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;

    vecs[0] = '{5'b0_0101, 5'b0_0011, 5'b0_0010, 1'b0, 4};
    vecs[1] = '{5'b0_0011, 5'b0_0101, 5'b1_0010, 1'b0, 8};
    vecs[2] = '{5'b0_1001, 5'b1_1001, 5'b0_0010, 1'b1, 4};
    vecs[3] = '{5'b1_0111, 5'b1_0111, 5'b0_0000, 1'b0, 4};
    vecs[4] = '{5'b1_0000, 5'b0_0000, 5'b0_0000, 1'b0, 4};
    vecs[5] = '{5'b0_0000, 5'b0_1111, 5'b1_1111, 1'b0, 8};
    vecs[6] = '{5'b1_1111, 5'b0_0001, 5'b0_0000, 1'b1, 4};
    vecs[7] = '{5'b1_0011, 5'b1_0101, 5'b0_0010, 1'b0, 8};
    vecs[8] = '{5'b0_0111, 5'b0_0001, 5'b0_0110, 1'b0, 4};

    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset diff", int'(diff), 0);
    chk("reset overflow", int'(overflow), 0);
    chk("reset in_ready", int'(in_ready), 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].ov, vecs[i].lat, 0, $sformatf("vec%0d", i));

    // Backpressure with operand churn on the input side
    run_op(5'b0_0101, 5'b0_0011, 5'b0_0010, 1'b0, 4, 5, "backpressure");

    // Asynchronous reset while processing magnitude bit 2
    a = 5'b0_1110;
    b = 5'b0_0011;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset out_valid", int'(out_valid), 0);
    chk("midreset diff", int'(diff), 0);
    chk("midreset in_ready", int'(in_ready), 1);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    repeat (10) begin
      @(posedge clk); #1;
      chk("postreset no result", int'(out_valid), 0);
    end
    run_op(5'b0_0111, 5'b0_0001, 5'b0_0110, 1'b0, 4, 0, "after reset");

    for (int i = 0; i < 1000; i++) begin
      ra = 5'($urandom);
      rb = 5'($urandom);
      model(ra, rb, ed, eo, el);
      run_op(ra, rb, ed, eo, el, int'($urandom_range(0, 3)), $sformatf("rand%0d a=%b b=%b", i, ra, rb));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
